// File: rtl/jtcps1_linefb_pkg.sv
// Shared types for the line frame-buffer stage: drain FSM encoding and counter limits.
package jtcps1_linefb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_REQ  = 2'd2,
    ST_NEXT = 2'd3
  } drain_st_e;

  localparam logic [7:0] DROP_MAX = 8'hFF;

endpackage

// File: rtl/jtcps1_linefb_ram.sv
// Ping-pong line store: simple dual-port RAM, address MSB selects the bank, registered read.
module jtcps1_linefb_ram #(
  parameter int DW = 12,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW:0]   waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW:0]   raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**(AW+1)];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/jtcps1_linefb.sv
// Captures visible pixels into one bank of a ping-pong line buffer and drains the
// previously completed line to the frame buffer through a write/acknowledge handshake.
module jtcps1_linefb
  import jtcps1_linefb_pkg::*;
#(
  parameter int DW    = 12,
  parameter int AW    = 9,
  parameter int HLEN  = 384,
  parameter bit SKIP0 = 1'b0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic          LVBL,
  input  logic [8:0]    vdump,
  input  logic [DW-1:0] pxl_data,
  output logic [DW-1:0] line_data,
  output logic [AW-1:0] line_addr,
  output logic [8:0]    line_y,
  output logic          line_wr,
  input  logic          line_wr_ok,
  output logic          frame_done,
  output logic [7:0]    drop_cnt,
  output logic          ovf,
  output drain_st_e     dbg_state
);

  localparam logic [AW:0] HLEN_W = (AW+1)'(HLEN);

  logic          lhbl_l_q, lvbl_l_q;
  logic          cap_bank_q, drain_bank_q;
  logic [AW:0]   hcnt_q, len_q, x_q, x_d;
  logic [8:0]    line_y_q;
  logic [7:0]    drop_q;
  logic          ovf_q, fd_flag_q;
  drain_st_e     st_q, st_d;
  logic [DW-1:0] rd_data;
  logic          cap_en, cap_wr, line_end, swap, lvbl_fall, lvbl_rise, skip;

  assign cap_en    = pxl_cen & LHBL & LVBL;
  assign cap_wr    = cap_en && (hcnt_q != HLEN_W);
  assign line_end  = pxl_cen & lhbl_l_q & ~LHBL & LVBL & (hcnt_q != '0);
  assign swap      = line_end && (st_q == ST_IDLE);
  assign lvbl_fall = pxl_cen & lvbl_l_q & ~LVBL;
  assign lvbl_rise = pxl_cen & ~lvbl_l_q & LVBL;

  // Pulse only once the last line of the frame has left the buffer.
  assign frame_done = fd_flag_q && (st_q == ST_IDLE) && !swap;

  assign line_y    = line_y_q;
  assign drop_cnt  = drop_q;
  assign ovf       = ovf_q;
  assign dbg_state = st_q;

  jtcps1_linefb_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk     (clk),
    .we_i    (cap_wr),
    .waddr_i ({cap_bank_q, hcnt_q[AW-1:0]}),
    .wdata_i (pxl_data),
    .raddr_i ({drain_bank_q, x_q[AW-1:0]}),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lhbl_l_q     <= 1'b0;
      lvbl_l_q     <= 1'b0;
      cap_bank_q   <= 1'b0;
      drain_bank_q <= 1'b0;
      hcnt_q       <= '0;
      len_q        <= '0;
      x_q          <= '0;
      line_y_q     <= '0;
      drop_q       <= '0;
      ovf_q        <= 1'b0;
      fd_flag_q    <= 1'b0;
      st_q         <= ST_IDLE;
    end else begin
      if (pxl_cen) begin
        lhbl_l_q <= LHBL;
        lvbl_l_q <= LVBL;
      end
      if (line_end)    hcnt_q <= '0;
      else if (cap_wr) hcnt_q <= hcnt_q + 1'b1;
      if (cap_en && hcnt_q == HLEN_W) ovf_q <= 1'b1;
      // A line ending while the drain is busy is discarded and its bank rewritten.
      if (swap) begin
        cap_bank_q   <= ~cap_bank_q;
        drain_bank_q <= cap_bank_q;
        len_q        <= hcnt_q;
        line_y_q     <= vdump;
      end else if (line_end && drop_q != DROP_MAX) begin
        drop_q <= drop_q + 1'b1;
      end
      if (lvbl_rise || frame_done) fd_flag_q <= 1'b0;
      else if (lvbl_fall)          fd_flag_q <= 1'b1;
      st_q <= st_d;
      x_q  <= x_d;
    end
  end

  // Handshake: in REQ, line_wr/line_addr/line_data stay constant until line_wr_ok
  // is sampled high on a clock edge; that edge completes the transfer and line_wr
  // drops. line_wr_ok seen while line_wr is low has no effect.
  always_comb begin
    st_d      = st_q;
    x_d       = x_q;
    line_wr   = 1'b0;
    line_addr = '0;
    line_data = '0;
    skip      = SKIP0 && (rd_data == '0);
    unique case (st_q)
      ST_IDLE: begin
        if (swap) begin
          st_d = ST_READ;
          x_d  = '0;
        end
      end
      ST_READ: st_d = ST_REQ;
      ST_REQ: begin
        if (skip) begin
          st_d = ST_NEXT;
        end else begin
          line_wr   = 1'b1;
          line_addr = x_q[AW-1:0];
          line_data = rd_data;
          if (line_wr_ok) st_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        x_d  = x_q + 1'b1;
        st_d = (x_d == len_q) ? ST_IDLE : ST_READ;
      end
      default: st_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_jtcps1_linefb.sv
// Directed bench for jtcps1_linefb: table of line scenarios plus hand-written handshake,
// drop, transparent-skip, frame_done and mid-drain reset sequences.
module tb_jtcps1_linefb;
  import jtcps1_linefb_pkg::*;

  localparam int DW   = 12;
  localparam int AW   = 9;
  localparam int HLEN = 384;
  localparam int EW   = 9 + AW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, pxl_cen, LHBL, LVBL, line_wr_ok, ack_hold;
  logic [8:0]    vdump;
  logic [DW-1:0] pxl_data;
  logic [DW-1:0] line_data, line_data_s;
  logic [AW-1:0] line_addr, line_addr_s;
  logic [8:0]    line_y, line_y_s;
  logic          line_wr, line_wr_s, frame_done, frame_done_s, ovf, ovf_s;
  logic [7:0]    drop_cnt, drop_cnt_s;
  drain_st_e     dbg_state, dbg_state_s;

  jtcps1_linefb #(.DW(DW), .AW(AW), .HLEN(HLEN), .SKIP0(1'b0)) dut (
    .clk(clk), .rstn(rstn), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .vdump(vdump), .pxl_data(pxl_data), .line_data(line_data), .line_addr(line_addr),
    .line_y(line_y), .line_wr(line_wr), .line_wr_ok(line_wr_ok),
    .frame_done(frame_done), .drop_cnt(drop_cnt), .ovf(ovf), .dbg_state(dbg_state)
  );

  jtcps1_linefb #(.DW(DW), .AW(AW), .HLEN(HLEN), .SKIP0(1'b1)) dut_s (
    .clk(clk), .rstn(rstn), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .vdump(vdump), .pxl_data(pxl_data), .line_data(line_data_s), .line_addr(line_addr_s),
    .line_y(line_y_s), .line_wr(line_wr_s), .line_wr_ok(1'b1),
    .frame_done(frame_done_s), .drop_cnt(drop_cnt_s), .ovf(ovf_s), .dbg_state(dbg_state_s)
  );

  // ---------------- counters / scoreboard ----------------
  int n_cmp = 0, n_fail = 0, n_wr = 0, n_wr_s = 0, n_fd = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_s_q[$];
  logic          skip_chk = 1'b0;
  logic          pend_v = 1'b0;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_data;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Frame-buffer side: acknowledge every request on the next edge unless stalled.
  always @(posedge clk) begin
    #1;
    line_wr_ok = line_wr && !ack_hold;
  end

  always @(negedge clk) begin
    logic [EW-1:0] e, g;
    if (!rstn) begin
      pend_v = 1'b0;
    end else begin
      if (pend_v) begin
        n_cmp++;
        if (!line_wr || line_addr != pend_addr || line_data != pend_data) begin
          n_fail++;
          $display("FAIL hold_stable: got wr=%0b addr=%0d data=%h, expected wr=1 addr=%0d data=%h",
                   line_wr, line_addr, line_data, pend_addr, pend_data);
        end
      end
      pend_v = 1'b0;
      if (line_wr && !line_wr_ok) begin
        pend_v = 1'b1; pend_addr = line_addr; pend_data = line_data;
      end
      if (line_wr && line_wr_ok) begin
        n_wr++;
        n_cmp++;
        g = {line_y, line_addr, line_data};
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL write_unexpected: got y=%0d addr=%0d data=%h, expected no write",
                   line_y, line_addr, line_data);
        end else begin
          e = exp_q.pop_front();
          if (g != e) begin
            n_fail++;
            $display("FAIL write: got y=%0d addr=%0d data=%h, expected y=%0d addr=%0d data=%h",
                     g[EW-1 -: 9], g[AW+DW-1 -: AW], g[DW-1:0],
                     e[EW-1 -: 9], e[AW+DW-1 -: AW], e[DW-1:0]);
          end
        end
      end
      if (frame_done) n_fd++;
      if (skip_chk && line_wr_s) begin
        n_wr_s++;
        n_cmp++;
        g = {line_y_s, line_addr_s, line_data_s};
        if (exp_s_q.size() == 0) begin
          n_fail++;
          $display("FAIL skip_unexpected: got addr=%0d data=%h, expected no write", line_addr_s, line_data_s);
        end else begin
          e = exp_s_q.pop_front();
          if (g != e) begin
            n_fail++;
            $display("FAIL skip_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                     g[AW+DW-1 -: AW], g[DW-1:0], e[AW+DW-1 -: AW], e[DW-1:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [DW-1:0] pix_val(input int pat, input int i);
    case (pat)
      0:       return DW'(i);
      1:       return DW'(i * 7 + 3);
      2:       return DW'(~i);
      3:       return (i % 2 == 1) ? DW'(5) : DW'(0);
      default: return '0;
    endcase
  endfunction

  task automatic run_line(input int npix, input int pat, input logic [8:0] vl, input bit push);
    int n;
    n = (npix < HLEN) ? npix : HLEN;
    if (push) begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({vl, AW'(i), pix_val(pat, i)});
        if (skip_chk && pix_val(pat, i) != '0) exp_s_q.push_back({vl, AW'(i), pix_val(pat, i)});
      end
    end
    vdump = vl;
    LHBL  = 1'b1;
    for (int i = 0; i < npix; i++) begin
      pxl_data = pix_val(pat, i);
      @(posedge clk); #1;
    end
    LHBL = 1'b0;
    pxl_data = '0;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (dbg_state != ST_IDLE && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_done_in_budget", (dbg_state == ST_IDLE), 1);
  endtask

  typedef struct {
    int         npix;
    int         pat;
    logic [8:0] vl;
    int         exp_wr;
    logic       exp_ovf;
    logic [7:0] exp_drop;
  } vec_t;
  vec_t vecs[7];

  initial begin
    #1ms;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int wr0, fd0, ws0, k_wait;
    vecs[0] = '{384, 0, 9'd16, 384, 1'b0, 8'd0};
    vecs[1] = '{ 10, 1, 9'd17,  10, 1'b0, 8'd0};
    vecs[2] = '{  1, 2, 9'd18,   1, 1'b0, 8'd0};
    vecs[3] = '{383, 1, 9'd19, 383, 1'b0, 8'd0};
    vecs[4] = '{384, 2, 9'd20, 384, 1'b0, 8'd0};
    vecs[5] = '{400, 0, 9'd21, 384, 1'b1, 8'd0};
    vecs[6] = '{  5, 1, 9'd22,   5, 1'b1, 8'd0};

    rstn = 1'b0; pxl_cen = 1'b1; LHBL = 1'b0; LVBL = 1'b1;
    vdump = '0; pxl_data = '0; ack_hold = 1'b0; line_wr_ok = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_line_wr", line_wr, 0);
    check("rst_line_addr", line_addr, 0);
    check("rst_line_data", line_data, 0);
    check("rst_line_y", line_y, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_ovf", ovf, 0);
    check("rst_state_idle", (dbg_state == ST_IDLE), 1);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int k = 0; k < 7; k++) begin
      wr0 = n_wr;
      run_line(vecs[k].npix, vecs[k].pat, vecs[k].vl, 1'b1);
      wait_idle(5000);
      check("vec_writes", n_wr - wr0, vecs[k].exp_wr);
      check("vec_ovf", ovf, vecs[k].exp_ovf);
      check("vec_drop", drop_cnt, vecs[k].exp_drop);
      check("vec_line_y", line_y, vecs[k].vl);
      check("vec_queue_empty", exp_q.size(), 0);
    end
    check("no_frame_done_in_frame", n_fd, 0);

    // Acknowledge stalled for 50 clocks mid-line.
    wr0 = n_wr;
    run_line(120, 2, 9'd50, 1'b1);
    repeat (30) @(posedge clk);
    ack_hold = 1'b1;
    repeat (50) @(posedge clk);
    ack_hold = 1'b0;
    #1;
    wait_idle(5000);
    check("stall_writes", n_wr - wr0, 120);
    check("stall_queue_empty", exp_q.size(), 0);

    // Stall through two line ends: second line dropped, third drains.
    ack_hold = 1'b1;
    run_line(30, 1, 9'd60, 1'b1);
    run_line(30, 2, 9'd61, 1'b0);
    check("drop_cnt_after_busy_end", drop_cnt, 1);
    @(posedge clk);
    ack_hold = 1'b0;
    #1;
    wait_idle(5000);
    check("drop_first_line_y", line_y, 60);
    wr0 = n_wr;
    run_line(30, 0, 9'd62, 1'b1);
    wait_idle(5000);
    check("drop_third_writes", n_wr - wr0, 30);
    check("drop_cnt_holds", drop_cnt, 1);
    check("drop_queue_empty", exp_q.size(), 0);

    // Transparent pixels skipped by the SKIP0 instance.
    skip_chk = 1'b1;
    ws0 = n_wr_s;
    run_line(16, 3, 9'd70, 1'b1);
    wait_idle(5000);
    repeat (4) @(posedge clk);
    #1;
    skip_chk = 1'b0;
    check("skip_writes", n_wr_s - ws0, 8);
    check("skip_queue_empty", exp_s_q.size(), 0);
    check("skip_main_queue_empty", exp_q.size(), 0);

    // frame_done waits for the drain, then fires once; immediate when already idle.
    fd0 = n_fd;
    run_line(50, 1, 9'd80, 1'b1);
    LVBL = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("fd_held_while_busy", n_fd - fd0, 0);
    wait_idle(5000);
    repeat (4) @(posedge clk);
    #1;
    check("fd_after_drain", n_fd - fd0, 1);
    LVBL = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    fd0 = n_fd;
    LVBL = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("fd_when_idle", n_fd - fd0, 1);
    LVBL = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-drain at x = 100.
    run_line(200, 0, 9'd90, 1'b1);
    k_wait = 0;
    while (!(line_wr && line_addr == AW'(100)) && k_wait < 2000) begin
      @(negedge clk);
      k_wait++;
    end
    check("reached_x100", (line_wr && line_addr == AW'(100)), 1);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_mid_line_wr", line_wr, 0);
    check("rst_mid_drop_cnt", drop_cnt, 0);
    check("rst_mid_ovf", ovf, 0);
    check("rst_mid_idle", (dbg_state == ST_IDLE), 1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    wr0 = n_wr;
    fd0 = n_fd;
    run_line(20, 1, 9'd91, 1'b1);
    LVBL = 1'b0;
    wait_idle(5000);
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_writes", n_wr - wr0, 20);
    check("post_rst_queue_empty", exp_q.size(), 0);
    check("post_rst_frame_done", n_fd - fd0, 1);
    LVBL = 1'b1;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
